clk_div_multi: RTL and testbench



---
 rtl/clk_div_multi.sv | 55 +++++
 tb/tb_clk_div_multi.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// N-channel programmable clock divider / tick-enable generator.
// Ports: clk100mhz, rst_n (sync, active-low), en/load per channel,
//        div_in (packed W-bit divisors), sync_clr (restart all),
//        tick (one-cycle pulse per period), clk_out (50% divided clock).
module clk_div_multi #(
    parameter int N           = 2,
    parameter int W           = 26,
    parameter int DEFAULT_DIV = 262144
) (
    input  logic           clk100mhz,
    input  logic           rst_n,
    input  logic [N-1:0]   en,
    input  logic [N-1:0]   load,
    input  logic [N*W-1:0] div_in,
    input  logic           sync_clr,
    output logic [N-1:0]   tick,
    output logic [N-1:0]   clk_out
);

    logic [W-1:0] div_reg [N];
    logic [W-1:0] cnt     [N];

    always_ff @(posedge clk100mhz) begin
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                div_reg[i] <= W'(DEFAULT_DIV);
                cnt[i]     <= '0;
                tick[i]    <= 1'b0;
                clk_out[i] <= 1'b0;
            end else if (load[i] || sync_clr) begin
                // sync_clr restarts phase but keeps the divisor
                // unless this channel is also loading.
                if (load[i]) begin
                    div_reg[i] <= div_in[i*W +: W];
                end
                cnt[i]     <= '0;
                tick[i]    <= 1'b0;
                clk_out[i] <= 1'b0;
            end else if (en[i] && (div_reg[i] != '0)) begin
                if (cnt[i] == div_reg[i] - W'(1)) begin
                    cnt[i]     <= '0;
                    tick[i]    <= 1'b1;
                    clk_out[i] <= ~clk_out[i];
                end else begin
                    cnt[i]  <= cnt[i] + W'(1);
                    tick[i] <= 1'b0;
                end
            end else begin
                // Paused or halted (divisor 0): hold phase, no tick.
                tick[i] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi (N=2, W=8, DEFAULT_DIV=4).
// Reference model tracks enabled cycles elapsed since the last restart.
module tb_clk_div_multi;

    localparam int N  = 2;
    localparam int W  = 8;
    localparam int DD = 4;

    logic           clk100mhz = 1'b0;
    logic           rst_n     = 1'b0;
    logic [N-1:0]   en        = '0;
    logic [N-1:0]   load      = '0;
    logic [N*W-1:0] div_in    = '0;
    logic           sync_clr  = 1'b0;
    logic [N-1:0]   tick;
    logic [N-1:0]   clk_out;

    int n_checks = 0;
    int n_fail   = 0;

    int md [N];
    int el [N];

    clk_div_multi #(
        .N(N),
        .W(W),
        .DEFAULT_DIV(DD)
    ) dut (
        .clk100mhz(clk100mhz),
        .rst_n(rst_n),
        .en(en),
        .load(load),
        .div_in(div_in),
        .sync_clr(sync_clr),
        .tick(tick),
        .clk_out(clk_out)
    );

    always #5 clk100mhz = ~clk100mhz;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, advance model at posedge,
    // compare outputs 1 time unit later.
    task automatic cyc(input logic r,
                       input logic [N-1:0] e,
                       input logic [N-1:0] l,
                       input logic [N*W-1:0] d,
                       input logic s);
        logic [N-1:0] xt;
        logic [N-1:0] xc;
        @(negedge clk100mhz);
        rst_n    = r;
        en       = e;
        load     = l;
        div_in   = d;
        sync_clr = s;
        @(posedge clk100mhz);
        for (int i = 0; i < N; i++) begin
            xt[i] = 1'b0;
            if (!r) begin
                md[i] = DD;
                el[i] = 0;
            end else if (l[i] || s) begin
                if (l[i]) md[i] = int'(d[i*W +: W]);
                el[i] = 0;
            end else if (e[i] && md[i] != 0) begin
                el[i]++;
                xt[i] = (el[i] % md[i]) == 0;
            end
            xc[i] = (md[i] == 0) ? 1'b0
                  : (((el[i] / md[i]) % 2) == 1);
        end
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("tick%0d", i), 32'(tick[i]), 32'(xt[i]));
            check($sformatf("clk%0d", i),
                  32'(clk_out[i]), 32'(xc[i]));
        end
    endtask

    task automatic run(input int n, input logic [N-1:0] e);
        for (int k = 0; k < n; k++) cyc(1'b1, e, '0, '0, 1'b0);
    endtask

    initial begin
        int tcount;
        // reset state
        cyc(1'b0, '0, '0, '0, 1'b0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_clk", 32'(clk_out), 32'd0);

        // release, both channels div 4
        tcount = 0;
        for (int k = 0; k < 12; k++) begin
            cyc(1'b1, 2'b11, '0, '0, 1'b0);
            tcount += int'(tick[0]);
        end
        check("ticks12", 32'(tcount), 32'd3);

        // load 3 on ch1, ch0 keeps phase
        cyc(1'b1, 2'b11, 2'b10, {8'd3, 8'd0}, 1'b0);
        run(10, 2'b11);

        // div 1 on ch0, then div 0 halt
        cyc(1'b1, 2'b11, 2'b01, {8'd0, 8'd1}, 1'b0);
        run(6, 2'b11);
        cyc(1'b1, 2'b11, 2'b01, {8'd0, 8'd0}, 1'b0);
        run(6, 2'b11);
        check("halt_clk0", 32'(clk_out[0]), 32'd0);

        // pause ch0 at cnt=2 for 5 cycles
        cyc(1'b0, '0, '0, '0, 1'b0);
        run(2, 2'b11);
        run(5, 2'b10);
        run(1, 2'b11);
        check("pause_t1", 32'(tick[0]), 32'd0);
        run(1, 2'b11);
        check("pause_t2", 32'(tick[0]), 32'd1);

        // sync_clr with ch0 cnt=1, ch1 cnt=2
        cyc(1'b0, '0, '0, '0, 1'b0);
        run(1, 2'b10);
        run(1, 2'b11);
        cyc(1'b1, 2'b11, '0, '0, 1'b1);
        check("clr_clk", 32'(clk_out), 32'd0);
        run(3, 2'b11);
        run(1, 2'b11);
        check("clr_tick", 32'(tick), 32'd3);

        // reset mid-count after load 7
        cyc(1'b1, 2'b11, 2'b11, {8'd7, 8'd7}, 1'b0);
        run(5, 2'b11);
        cyc(1'b0, 2'b11, '0, '0, 1'b0);
        check("mid_rst", 32'({tick, clk_out}), 32'd0);
        run(12, 2'b11);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            logic [N-1:0]   rl;
            logic [N*W-1:0] rd;
            for (int i = 0; i < N; i++) begin
                rl[i] = ($urandom_range(0, 19) == 0);
                rd[i*W +: W] = W'($urandom_range(0, 9));
            end
            cyc($urandom_range(0, 99) != 0,
                N'($urandom), rl, rd,
                $urandom_range(0, 29) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
